// File: rtl/sp_ram_arb_pkg.sv
// Shared types and limits for the single-port RAM request arbiter.
package sp_ram_arb_pkg;

    // Master identity; also the value stored in a response tag.
    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_AXI  = 1'b1
    } arb_port_e;

    // One in-flight response slot.
    typedef struct packed {
        logic      valid;
        arb_port_e port;
    } rsp_tag_t;

    // Deepest RAM read latency the response pipeline supports.
    localparam int MAX_RD_LATENCY = 4;

endpackage

// File: rtl/sp_ram_rsp_pipe.sv
// Response tag delay line: a tag pushed in cycle t appears on tag_o during
// cycle t+DEPTH. Synchronous active-low clear drops every in-flight tag.
module sp_ram_rsp_pipe
    import sp_ram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rstn_i,
    input  rsp_tag_t tag_i,
    output rsp_tag_t tag_o
);

    rsp_tag_t pipe_q [DEPTH];
    rsp_tag_t pipe_d [DEPTH];

    // Shift every stage down by one; stage 0 takes the new tag.
    always_comb begin
        pipe_d[0] = tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rstn_i) begin
                pipe_q[i] <= '0;
            end else begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sp_ram_req_arb.sv
// Two-master request arbiter and response router in front of sp_ram_wrap.
// Port 0 is the core data port, port 1 the AXI/debug port.
// Build option: SP_RAM_ARB_RR_EN selects round-robin arbitration; when it is
// undefined port 0 always wins and no pointer register exists.
module sp_ram_req_arb
    import sp_ram_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 15,
    parameter int          DATA_WIDTH = 32,
    parameter int          RD_LATENCY = 2,
    parameter int unsigned ACC_BASE   = 'h400,
    parameter int unsigned ACC_LAST   = 'hBFF
) (
    input  logic                    clk,
    input  logic                    rstn_i,

    input  logic                    p0_req_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,

    input  logic                    p1_req_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,

    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_bypass_en_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] ACC_BASE_A = ACC_BASE[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] ACC_LAST_A = ACC_LAST[ADDR_WIDTH-1:0];

    logic     gnt0;
    logic     gnt1;
    rsp_tag_t tag_push;
    rsp_tag_t tag_out;

`ifdef SP_RAM_ARB_RR_EN
    // ptr_q names the port that wins the next two-way contention.
    arb_port_e ptr_q;
    arb_port_e ptr_d;

    // Hand the pointer to the loser whenever both ports competed.
    always_comb begin
        ptr_d = ptr_q;
        if (p0_req_i && p1_req_i) begin
            ptr_d = gnt0 ? PORT_AXI : PORT_CORE;
        end
    end

    // Pointer register; reset favours the core port.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            ptr_q <= PORT_CORE;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Round-robin grant; a lone requester always wins. Nothing is granted in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rstn_i) begin
            if (p0_req_i && p1_req_i) begin
                gnt0 = (ptr_q == PORT_CORE);
                gnt1 = (ptr_q == PORT_AXI);
            end else begin
                gnt0 = p0_req_i;
                gnt1 = p1_req_i;
            end
        end
    end
`else
    // Fixed priority grant: the core port always wins. Nothing is granted in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rstn_i) begin
            gnt0 = p0_req_i;
            gnt1 = p1_req_i && !p0_req_i;
        end
    end
`endif

    assign p0_gnt_o = gnt0;
    assign p1_gnt_o = gnt1;

    // Steer the granted port onto the RAM request; all zero when idle.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (gnt0) begin
            ram_en_o    = 1'b1;
            ram_we_o    = p0_we_i;
            ram_be_o    = p0_be_i;
            ram_addr_o  = p0_addr_i;
            ram_wdata_o = p0_wdata_i;
        end else if (gnt1) begin
            ram_en_o    = 1'b1;
            ram_we_o    = p1_we_i;
            ram_be_o    = p1_be_i;
            ram_addr_o  = p1_addr_i;
            ram_wdata_o = p1_wdata_i;
        end
    end

    // Accelerator window hit, inclusive at both ends, only for a live request.
    always_comb begin
        ram_bypass_en_o = ram_en_o
                          && (ram_addr_o >= ACC_BASE_A)
                          && (ram_addr_o <= ACC_LAST_A);
    end

    // Every grant, read or write, launches one response tag.
    always_comb begin
        tag_push.valid = gnt0 || gnt1;
        tag_push.port  = gnt1 ? PORT_AXI : PORT_CORE;
    end

    sp_ram_rsp_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rsp_pipe (
        .clk    (clk),
        .rstn_i (rstn_i),
        .tag_i  (tag_push),
        .tag_o  (tag_out)
    );

    // Route the emerging tag to its master; read data is shared and qualified by rvalid.
    always_comb begin
        p0_rvalid_o = tag_out.valid && (tag_out.port == PORT_CORE);
        p1_rvalid_o = tag_out.valid && (tag_out.port == PORT_AXI);
        p0_rdata_o  = ram_rdata_i;
        p1_rdata_o  = ram_rdata_i;
    end

endmodule

// File: doc/sp_ram_req_arb.md
# sp_ram_req_arb

Two-master request arbiter and response tracker sitting directly upstream of `sp_ram_wrap`. It accepts req/gnt transactions from two masters, the core data port (port 0) and the AXI/debug port (port 1). It drives the single-port RAM wrapper's `en/addr/wdata/we/be/bypass_en` inputs. It routes the wrapper's `rdata` back to the correct master with an `rvalid` pulse after the fixed RAM read latency.

## Interface
Parameters:
- `ADDR_WIDTH`, 15: byte address width; matches the RAM wrapper.
- `DATA_WIDTH`, 32: data width; byte enables are `DATA_WIDTH/8`.
- `RD_LATENCY`, 2: cycles from grant to `rdata` valid at the wrapper output. Legal range is 1..4.
- `ACC_BASE`, 'h400: first byte address of the accelerator window.
- `ACC_LAST`, 'hBFF: last byte address of the accelerator window.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn_i` in 1: reset, synchronous, active-low.
- `pN_req_i` in 1 (N=0,1): master request.
- `pN_we_i` in 1: 1 = write.
- `pN_be_i` in DATA_WIDTH/8: byte enables.
- `pN_addr_i` in ADDR_WIDTH: byte address.
- `pN_wdata_i` in DATA_WIDTH: write data.
- `pN_gnt_o` out 1: request accepted this cycle.
- `pN_rvalid_o` out 1: response valid.
- `pN_rdata_o` out DATA_WIDTH: read data.
- `ram_en_o` out 1; `ram_we_o` out 1; `ram_be_o` out DATA_WIDTH/8; `ram_addr_o` out ADDR_WIDTH; `ram_wdata_o` out DATA_WIDTH: RAM wrapper request.
- `ram_bypass_en_o` out 1: the granted address lies in [ACC_BASE, ACC_LAST].
- `ram_rdata_i` in DATA_WIDTH: RAM wrapper read data.

## Operation
- Grant is combinational.
  - At most one of `p0_gnt_o`/`p1_gnt_o` is high in any cycle.
  - `pN_gnt_o` is high only if `pN_req_i` is high.
  - If any request is present, exactly one is granted: the arbiter is work-conserving.
- RAM mux:
  - `ram_en_o` = (any grant).
  - `ram_addr_o`, `ram_we_o`, `ram_be_o` and `ram_wdata_o` come from the granted port.
  - When there is no grant these outputs are 0.
- The window comparison is inclusive at both ends.
- Response tracking:
  - Each grant pushes a tag {valid, port} into a shift pipeline `RD_LATENCY` deep.
  - On the pipeline output, `pN_rvalid_o` = tag.valid & (tag.port==N).
  - Both ports' `pN_rdata_o` are driven with `ram_rdata_i` unconditionally; it is qualified only by rvalid.
- Writes also return an rvalid, with don't-care rdata. Every grant produces exactly one rvalid.
- Back-to-back grants are allowed every cycle. Throughput is 1 transaction per cycle.
- Masters hold `req`, `addr`, `we`, `be` and `wdata` stable until granted. Dropping `req` before grant is legal; that request is simply not served.

## Timing
- Reset (`rstn_i` low at an edge):
  - The tag pipeline and the round-robin pointer are cleared; the pointer favours port 0.
  - While `rstn_i` is low, all `gnt_o` and `ram_en_o` are forced to 0. `rvalid_o` = 0 from the cycle after the reset edge.
- Reset mid-operation: in-flight tags are discarded, and no rvalid is issued for them.
- Latency: a grant at cycle t gives `pN_rvalid_o` high during cycle t+RD_LATENCY.
- Simultaneous requests: arbitration follows the Configuration rules below. The loser's gnt stays low and it retries next cycle.
- Pointer update: at the edge after a cycle in which both ports requested, the pointer moves to the non-granted port. With a single requester the pointer is unchanged.

## Configuration
- `SP_RAM_ARB_RR_EN` defined: round-robin between the ports. Each port is guaranteed a grant within 2 cycles of continuous request.
- Macro undefined: fixed priority, with port 0 always winning. The pointer register is not instantiated. Port 1 may starve under continuous port-0 traffic.

## Structure
- Package `sp_ram_arb_pkg` holds:
  - typedef `arb_port_e` (PORT_CORE=0, PORT_AXI=1);
  - typedef `rsp_tag_t` {valid, port};
  - localparam `MAX_RD_LATENCY` = 4.
- Sub-module `sp_ram_rsp_pipe` implements the `RD_LATENCY`-deep tag shift register with synchronous active-low clear.

## Test plan
- Single port-0 read of addr 'h0010, RAM returns 'hDEADBEEF at t+2:
  - `p0_gnt_o` is high at t.
  - `p0_rvalid_o` is high at t+2 with rdata 'hDEADBEEF.
  - `p1_rvalid_o` stays 0.
- Both ports request continuously for 6 cycles:
  - With RR_EN: grants are 0,1,0,1,0,1 and rvalids follow 2 cycles later, port-matched.
  - Without RR_EN: all six grants go to port 0.
- Window boundaries, addresses 'h3FF, 'h400, 'hBFF and 'hC00: `ram_bypass_en_o` = 0, 1, 1, 0 respectively.
- Port-1 write, be='b0011, wdata 'h12345678: `ram_we_o`=1, `ram_be_o`='b0011 and `ram_wdata_o`='h12345678 in the grant cycle, and `p1_rvalid_o` pulses at t+2.
- Grants at t and t+1, then `rstn_i` low at t+1: no rvalid at t+2 or t+3, and `ram_en_o` = 0 while reset is held.
- `RD_LATENCY`=1 build, 4 back-to-back alternating reads: each rvalid arrives exactly 1 cycle after its grant, on the correct port.
